// File: rtl/alu_serial_if.sv
// Valid/ready bundle for the serial ALU.
// Request side carries operands, response side carries result and flags.
interface alu_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, A, B, control, out_ready,
    input  in_ready, out_valid, out,
    input  carryout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, A, B, control, out_ready,
    output in_ready, out_valid, out,
    output carryout, overflow, zero, negative
  );
endinterface

// File: rtl/alu_serial.sv
// Multi-cycle ALU over a SLICE-bit datapath with a registered ripple carry.
// WIDTH must be a multiple of SLICE; one op takes WIDTH/SLICE + 1 cycles.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic clock,
  input  logic reset,
  alu_serial_if.slave bus
);

  localparam int NSTEP = WIDTH / SLICE;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic             in_ready;
  logic             out_valid;
  logic             accept;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctl_q;
  logic [CW-1:0]    cnt;
  logic             fin;
  logic             carry;
  logic             ovf_q;
  logic [WIDTH-1:0] res;

  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             ovfl_q;
  logic             zero_q;
  logic             neg_q;

  logic             arith;
  logic             is_sub;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;
  logic             cin_msb;
  logic [SLICE-1:0] r_s;

  assign accept = bus.in_valid && in_ready;
  assign is_sub = (ctl_q == OP_SUB);
  assign arith  = (ctl_q == OP_ADD) || is_sub;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        if (fin) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One slice of the ALU; operands are shifted down so slice 0 is current
  always_comb begin
    a_s     = a_q[SLICE-1:0];
    b_eff   = is_sub ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    sum     = {1'b0, a_s} + {1'b0, b_eff}
            + (SLICE+1)'(carry);
    cin_msb = a_s[SLICE-1] ^ b_eff[SLICE-1]
            ^ sum[SLICE-1];
    r_s     = '0;
    unique case (1'b1)
      arith:            r_s = sum[SLICE-1:0];
      ctl_q == OP_AND:  r_s = a_s & b_q[SLICE-1:0];
      ctl_q == OP_OR:   r_s = a_s | b_q[SLICE-1:0];
      ctl_q == OP_NOR:  r_s = ~(a_s | b_q[SLICE-1:0]);
      ctl_q == OP_XOR:  r_s = a_s ^ b_q[SLICE-1:0];
      default:          r_s = '0;
    endcase
  end

  // Operand latch, slice stepping and flag capture on entry to DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      ctl_q  <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      carry  <= 1'b0;
      ovf_q  <= 1'b0;
      res    <= '0;
      out_q  <= '0;
      cout_q <= 1'b0;
      ovfl_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      ctl_q <= bus.control;
      cnt   <= '0;
      fin   <= 1'b0;
      carry <= (bus.control == OP_SUB);
      ovf_q <= 1'b0;
    end else if (state == RUN) begin
      if (!fin) begin
        a_q <= a_q >> SLICE;
        b_q <= b_q >> SLICE;
        res <= (res >> SLICE)
             | (WIDTH'(r_s) << (WIDTH - SLICE));
        if (arith) begin
          carry <= sum[SLICE];
          ovf_q <= cin_msb ^ sum[SLICE];
        end
        if (cnt == LAST) fin <= 1'b1;
        else             cnt <= cnt + 1'b1;
      end else begin
        out_q  <= res;
        cout_q <= arith && carry;
        ovfl_q <= arith && ovf_q;
        zero_q <= (res == '0);
        neg_q  <= res[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;
  assign bus.carryout  = cout_q;
  assign bus.overflow  = ovfl_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed checks of alu_serial (8/1) plus a 32/4 instance
// compared against a full-width arithmetic model.
module tb_alu_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(8))  b8 ();
  alu_serial_if #(.WIDTH(32)) b32 ();

  alu_serial #(.WIDTH(8), .SLICE(1)) dut8 (
    .clock(clk),
    .reset(rst),
    .bus  (b8.slave)
  );

  alu_serial #(.WIDTH(32), .SLICE(4)) dut32 (
    .clock(clk),
    .reset(rst),
    .bus  (b32.slave)
  );

  // {out, carryout, overflow, zero, negative}
  function automatic logic [11:0] obs8();
    return {b8.out, b8.carryout, b8.overflow,
            b8.zero, b8.negative};
  endfunction

  function automatic logic [35:0] obs32();
    return {b32.out, b32.carryout, b32.overflow,
            b32.zero, b32.negative};
  endfunction

  function automatic logic [35:0] model32(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  c
  );
    logic [32:0] s;
    logic [31:0] r;
    logic        co;
    logic        ov;
    s  = '0;
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (c)
      3'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd3: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = ~(a | b);
      3'd7: r = a ^ b;
      default: r = '0;
    endcase
    return {r, co, ov, (r == 32'd0), r[31]};
  endfunction

  task automatic op8(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] c,
    output int         lat
  );
    b8.A        = a;
    b8.B        = b;
    b8.control  = c;
    b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    b8.A        = ~a;
    b8.B        = ~b;
    b8.control  = 3'd7;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop8();
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  task automatic run8(
    input string      nm,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] c,
    input logic [11:0] exp
  );
    int lat;
    op8(a, b, c, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=9", nm, lat);
    end
    checks++;
    if (obs8() !== exp) begin
      errors++;
      $display("FAIL %s result got=%h exp=%h",
               nm, obs8(), exp);
    end
    pop8();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({b8.in_ready, b8.out_valid, obs8()}
        !== {2'b10, 12'h000}) begin
      errors++;
      $display("FAIL reset got=%b%b %h exp=10 000",
               b8.in_ready, b8.out_valid, obs8());
    end
  endtask

  task automatic test_add();
    run8("add_7f_01", 8'h7F, 8'h01, 3'd2,
         {8'h80, 4'b0101});
    run8("add_ff_01", 8'hFF, 8'h01, 3'd2,
         {8'h00, 4'b1010});
  endtask

  task automatic test_sub();
    run8("sub_05_05", 8'h05, 8'h05, 3'd3,
         {8'h00, 4'b1010});
    run8("sub_00_01", 8'h00, 8'h01, 3'd3,
         {8'hFF, 4'b0001});
    run8("sub_80_01", 8'h80, 8'h01, 3'd3,
         {8'h7F, 4'b1100});
  endtask

  task automatic test_logic();
    logic [2:0]  ctl [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    logic [11:0] exp [4] = '{{8'h30, 4'b0000},
                             {8'hFC, 4'b0001},
                             {8'h03, 4'b0000},
                             {8'hCC, 4'b0001}};
    for (int i = 0; i < 4; i++)
      run8("logic", 8'hF0, 8'h3C, ctl[i], exp[i]);
    run8("invalid1", 8'hF0, 8'h3C, 3'd1,
         {8'h00, 4'b0010});
    run8("invalid0", 8'hFF, 8'hFF, 3'd0,
         {8'h00, 4'b0010});
  endtask

  task automatic test_backpressure();
    int lat;
    op8(8'h12, 8'h34, 3'd2, lat);
    checks++;
    if (obs8() !== {8'h46, 4'b0000}) begin
      errors++;
      $display("FAIL bp_result got=%h exp=460", obs8());
    end
    for (int i = 0; i < 10; i++) begin
      b8.in_valid = i[0];
      b8.A        = 8'hAA;
      b8.control  = 3'd3;
      @(posedge clk); #1;
      checks++;
      if ({b8.out_valid, b8.in_ready, obs8()}
          !== {2'b10, 8'h46, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold got=%b%b %h exp=10 460",
                 b8.out_valid, b8.in_ready, obs8());
      end
    end
    b8.in_valid = 1'b0;
    pop8();
    checks++;
    if ({b8.in_ready, b8.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got=%b%b exp=10",
               b8.in_ready, b8.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    b8.A        = 8'h03;
    b8.B        = 8'h04;
    b8.control  = 3'd2;
    b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({b8.in_ready, b8.out_valid, obs8()}
        !== {2'b10, 12'h000}) begin
      errors++;
      $display("FAIL mid_reset got=%b%b %h exp=10 000",
               b8.in_ready, b8.out_valid, obs8());
    end
    run8("after_reset", 8'h01, 8'h01, 3'd2,
         {8'h02, 4'b0000});
  endtask

  task automatic test_back_to_back();
    int lat;
    op8(8'h0F, 8'h01, 3'd2, lat);
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    op8(8'h55, 8'hAA, 3'd7, lat);
    checks++;
    if ({lat[4:0], obs8()} !== {5'd9, 8'hFF, 4'b0001}) begin
      errors++;
      $display("FAIL b2b got=%0d %h exp=9 ff1",
               lat, obs8());
    end
    pop8();
  endtask

  task automatic test_random32();
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [35:0] exp;
    int          lat;
    int          k;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      c = 3'($urandom_range(0, 7));
      exp = model32(a, b, c);
      b32.A        = a;
      b32.B        = b;
      b32.control  = c;
      b32.in_valid = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      b32.A        = $urandom;
      lat = 0;
      while (b32.out_valid !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL r32_lat op=%0d got=%0d exp=9",
                 n, lat);
      end
      checks++;
      if (obs32() !== exp) begin
        errors++;
        $display("FAIL r32 a=%h b=%h c=%0d got=%h exp=%h",
                 a, b, c, obs32(), exp);
      end
      k = $urandom_range(0, 3);
      for (int s = 0; s < k; s++) begin
        @(posedge clk); #1;
        checks++;
        if ({b32.out_valid, obs32()} !== {1'b1, exp}) begin
          errors++;
          $display("FAIL r32_stall got=%b %h exp=1 %h",
                   b32.out_valid, obs32(), exp);
        end
      end
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.out_ready = 1'b0;
    end
  endtask

  initial begin
    b8.in_valid   = 1'b0;
    b8.A          = '0;
    b8.B          = '0;
    b8.control    = '0;
    b8.out_ready  = 1'b0;
    b32.in_valid  = 1'b0;
    b32.A         = '0;
    b32.B         = '0;
    b32.control   = '0;
    b32.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random32();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
